// File: rtl/range_filter_pipe.sv
// 3x3 edge-preserving range filter: similarity weights sharpened by repeated squaring,
// weighted mean via a pipelined restoring divider. Define RANGE_FILTER_BYPASS_EN to add a per-window bypass.
module range_filter_pipe #(
    parameter int DW        = 8,
    parameter int SQ_STAGES = 3,
    parameter int CENTER_W  = 248
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            in_valid,
    input  logic [9*DW-1:0] win_pixels,
`ifdef RANGE_FILTER_BYPASS_EN
    input  logic            bypass,
`endif
    output logic            out_valid,
    output logic [DW-1:0]   out_pixel
);

    localparam int SW  = DW + 4;
    localparam int SPW = 2 * DW + 4;
    localparam int NV  = SQ_STAGES + DW + 2;

    generate
        if (CENTER_W < 1 || CENTER_W > (1 << DW) - 1) begin : g_bad_center
            $error("range_filter_pipe: CENTER_W must lie in 1..2**DW-1");
        end
        if (DW < 4 || DW > 12) begin : g_bad_dw
            $error("range_filter_pipe: DW must lie in 4..12");
        end
        if (SQ_STAGES < 1 || SQ_STAGES > 6) begin : g_bad_sq
            $error("range_filter_pipe: SQ_STAGES must lie in 1..6");
        end
    endgenerate

    // (2^DW-1) - |p - c| is the bitwise inverse of the absolute difference
    function automatic logic [DW-1:0] similarity(input logic [DW-1:0] p, input logic [DW-1:0] c);
        logic [DW-1:0] diff;
        diff = (p >= c) ? p - c : c - p;
        return ~diff;
    endfunction

    function automatic logic [DW-1:0] sharpen(input logic [DW-1:0] w);
        logic [2*DW-1:0] sq;
        sq = {{DW{1'b0}}, w} * {{DW{1'b0}}, w};
        return sq[2*DW-1:DW];
    endfunction

    function automatic int nb_tap(input int n);
        return (n < 4) ? n : n + 1;
    endfunction

    function automatic logic q_bit(input logic [SPW-1:0] rem, input logic [SW-1:0] den, input int b);
        return rem >= (SPW'(den) << b);
    endfunction

    function automatic logic [SPW-1:0] rem_next(input logic [SPW-1:0] rem, input logic [SW-1:0] den,
                                                input int b);
        return q_bit(rem, den, b) ? rem - (SPW'(den) << b) : rem;
    endfunction

    logic [8:0][DW-1:0] taps_in;
    logic [8:0][DW-1:0] pix_p [0:SQ_STAGES];
    logic [7:0][DW-1:0] w_p   [0:SQ_STAGES];
    logic [NV-1:0]      vld_p;
    logic [SW-1:0]      sum_w_a1;
    logic [SPW-1:0]     sum_wp_a1;
    logic [SW-1:0]      sum_w_a2;
    logic [SPW-1:0]     sum_wp_a2;
    logic [SPW-1:0]     rem_d [1:DW-1];
    logic [SW-1:0]      den_d [1:DW-1];
    logic [DW-1:0]      quo_d [1:DW];
    logic [DW-1:0]      result_d;

    assign taps_in = win_pixels;

    // Valid shift chain: S0..S_SQ, A2, D1..D_DW
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p <= '0;
        end else if (en) begin
            vld_p <= {vld_p[NV-2:0], in_valid};
        end
    end

    // S0 capture and similarity, then S1..S_SQ squaring
    always_ff @(posedge clk) begin
        if (en) begin
            pix_p[0] <= taps_in;
            for (int n = 0; n < 8; n++) begin
                w_p[0][n] <= similarity(taps_in[nb_tap(n)], taps_in[4]);
            end
            for (int s = 1; s <= SQ_STAGES; s++) begin
                pix_p[s] <= pix_p[s-1];
                for (int n = 0; n < 8; n++) begin
                    w_p[s][n] <= sharpen(w_p[s-1][n]);
                end
            end
        end
    end

    // A1: weighted sums at full width
    always_comb begin
        sum_w_a1  = SW'(CENTER_W);
        sum_wp_a1 = SPW'(CENTER_W) * SPW'(pix_p[SQ_STAGES][4]);
        for (int n = 0; n < 8; n++) begin
            sum_w_a1  = sum_w_a1 + SW'(w_p[SQ_STAGES][n]);
            sum_wp_a1 = sum_wp_a1 + SPW'(w_p[SQ_STAGES][n]) * SPW'(pix_p[SQ_STAGES][nb_tap(n)]);
        end
    end

    // A2 register, then D1..D_DW, one quotient bit per stage MSB first
    always_ff @(posedge clk) begin
        if (en) begin
            sum_w_a2  <= sum_w_a1;
            sum_wp_a2 <= sum_wp_a1;
            rem_d[1]  <= rem_next(sum_wp_a2, sum_w_a2, DW - 1);
            den_d[1]  <= sum_w_a2;
            quo_d[1]  <= DW'(q_bit(sum_wp_a2, sum_w_a2, DW - 1)) << (DW - 1);
            for (int k = 2; k < DW; k++) begin
                rem_d[k] <= rem_next(rem_d[k-1], den_d[k-1], DW - k);
                den_d[k] <= den_d[k-1];
                quo_d[k] <= quo_d[k-1] | (DW'(q_bit(rem_d[k-1], den_d[k-1], DW - k)) << (DW - k));
            end
            quo_d[DW] <= quo_d[DW-1] | DW'(q_bit(rem_d[DW-1], den_d[DW-1], 0));
        end
    end

`ifdef RANGE_FILTER_BYPASS_EN
    logic [NV-1:0] byp_p;
    logic [DW-1:0] p5_a2;
    logic [DW-1:0] p5_d [1:DW];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byp_p <= '0;
        end else if (en) begin
            byp_p <= {byp_p[NV-2:0], in_valid & bypass};
        end
    end

    // Centre pixel rides alongside the sums and divider so a bypass keeps latency
    always_ff @(posedge clk) begin
        if (en) begin
            p5_a2   <= pix_p[SQ_STAGES][4];
            p5_d[1] <= p5_a2;
            for (int k = 2; k <= DW; k++) begin
                p5_d[k] <= p5_d[k-1];
            end
        end
    end

    assign result_d = byp_p[NV-1] ? p5_d[DW] : quo_d[DW];
`else
    assign result_d = quo_d[DW];
`endif

    // Output register: pixel only moves when a result arrives
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_pixel <= '0;
        end else if (en) begin
            out_valid <= vld_p[NV-1];
            if (vld_p[NV-1]) begin
                out_pixel <= result_d;
            end
        end
    end

endmodule

// File: tb/tb_range_filter_pipe.sv
// Self-checking bench for range_filter_pipe: directed windows plus random streams,
// stalls and reset, compared each cycle against an arithmetic reference model.
module tb_range_filter_pipe;

    localparam int DW = 8;
    localparam int SQ = 3;
    localparam int CW = 248;
    localparam int L  = SQ + DW + 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            en;
    logic            in_valid;
    logic [9*DW-1:0] win_pixels;
    logic            out_valid;
    logic [DW-1:0]   out_pixel;
`ifdef RANGE_FILTER_BYPASS_EN
    logic            bypass;
`endif

    int total = 0;
    int bad   = 0;
    int en_cnt;
    int last_out;
    int exp_pix [int];

    range_filter_pipe #(.DW(DW), .SQ_STAGES(SQ), .CENTER_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .in_valid   (in_valid),
        .win_pixels (win_pixels),
`ifdef RANGE_FILTER_BYPASS_EN
        .bypass     (bypass),
`endif
        .out_valid  (out_valid),
        .out_pixel  (out_pixel)
    );

    always #5 clk = ~clk;

    // Weighted mean of the window using plain integer arithmetic
    function automatic int ref_out(input logic [9*DW-1:0] px, input bit b);
        int p [9];
        int sw, swp, w, d;
        for (int k = 0; k < 9; k++) p[k] = int'(px[k*DW +: DW]);
        if (b) return p[4];
        sw  = CW;
        swp = CW * p[4];
        for (int k = 0; k < 9; k++) begin
            if (k != 4) begin
                d = (p[k] > p[4]) ? p[k] - p[4] : p[4] - p[k];
                w = ((1 << DW) - 1) - d;
                repeat (SQ) w = (w * w) / (1 << DW);
                sw  += w;
                swp += w * p[k];
            end
        end
        return swp / sw;
    endfunction

    function automatic logic [9*DW-1:0] win2(input int c, input int lo, input int hi);
        logic [9*DW-1:0] px;
        int v;
        for (int k = 0; k < 9; k++) begin
            v = (k < 4) ? lo : ((k == 4) ? c : hi);
            px[k*DW +: DW] = DW'(v);
        end
        return px;
    endfunction

    function automatic logic [9*DW-1:0] rand_win();
        logic [9*DW-1:0] px;
        int c, d;
        c = int'($urandom_range(0, 255));
        for (int k = 0; k < 9; k++) begin
            if ($urandom_range(0, 1) == 1) d = c + int'($urandom_range(0, 30)) - 15;
            else d = int'($urandom_range(0, 255));
            if (d < 0) d = 0;
            if (d > 255) d = 255;
            px[k*DW +: DW] = DW'(d);
        end
        return px;
    endfunction

    function automatic bit rand_byp();
`ifdef RANGE_FILTER_BYPASS_EN
        return bit'($urandom_range(0, 1));
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // One clock: drive, advance the model on an enabled edge, check on the falling edge
    task automatic cycle(input bit e, input bit v, input logic [9*DW-1:0] px, input int fexp, input bit b);
        int idx;
        bit exp_v;
        en         = e;
        in_valid   = v;
        win_pixels = px;
`ifdef RANGE_FILTER_BYPASS_EN
        bypass     = b;
`endif
        @(posedge clk);
        if (e) begin
            en_cnt++;
            if (v) exp_pix[en_cnt] = (fexp >= 0) ? fexp : ref_out(px, b);
        end
        @(negedge clk);
        idx   = en_cnt - (L - 1);
        exp_v = exp_pix.exists(idx);
        if (exp_v) last_out = exp_pix[idx];
        check("out_valid", 32'(out_valid), 32'(exp_v));
        check("out_pixel", 32'(out_pixel), 32'(last_out));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, '0, -1, 1'b0);
    endtask

    task automatic pulse_reset();
        en       = 1'b0;
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_valid", 32'(out_valid), 32'd0);
        check("rst_async_pixel", 32'(out_pixel), 32'd0);
        exp_pix.delete();
        last_out = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n      = 1'b0;
        en         = 1'b0;
        in_valid   = 1'b0;
        win_pixels = '0;
`ifdef RANGE_FILTER_BYPASS_EN
        bypass     = 1'b0;
`endif
        en_cnt     = 0;
        last_out   = 0;
        #1;
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_pixel", 32'(out_pixel), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Uniform window, isolated pulse
        cycle(1'b1, 1'b1, win2(100, 100, 100), 100, 1'b0);
        idle(L + 1);

        // Extreme contrasts, then a two-level edge (neighbour weight 4 after squaring)
        cycle(1'b1, 1'b1, win2(0, 255, 255), 0, 1'b0);
        cycle(1'b1, 1'b1, win2(255, 0, 0), 255, 1'b0);
        cycle(1'b1, 1'b1, win2(100, 100, 200), 101, 1'b0);
        idle(L + 1);

        // 20 back-to-back random windows
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, rand_win(), -1, rand_byp());
        idle(L + 1);

        // Five-cycle stall mid-stream; windows offered while stalled are not taken
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, rand_win(), -1, rand_byp());
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, rand_win(), -1, rand_byp());
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, rand_win(), -1, rand_byp());
        idle(L + 1);

        // Random bubbles and random enable
        for (int i = 0; i < 40; i++)
            cycle(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 1)), rand_win(), -1, rand_byp());
        idle(L + 1);

        // Reset with windows in flight and results streaming
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, rand_win(), -1, rand_byp());
        idle(2);
        pulse_reset();
        cycle(1'b1, 1'b1, rand_win(), -1, 1'b0);
        idle(L + 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
